dsi_lane_distributor: RTL and testbench

- Parametrised successor to the DSI lane data path: one synchronous block that replaces the fixed 4-lane byte split plus per-lane FIFOs.
- Takes a packet byte stream from the packet assembler and deals bytes round-robin across a runtime-selected number of lanes, up to LANES_MAX.
- Marks the last byte of each packet on every lane, with an LPM flag, so the lanes controller can end HS bursts per lane.
- Buffers each lane in its own FIFO for the lanes controller.

---
 rtl/dsi_lane_distributor_if.sv | 30 +++
 rtl/dsi_lane_distributor.sv | 212 +++++++++++++++++++++
 tb/tb_dsi_lane_distributor.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsi_lane_distributor_if.sv
// Bus bundle of the DSI lane distributor: packet-assembler word input,
// per-lane FIFO heads toward the lanes controller, and status.
interface dsi_lane_distributor_if #(
  parameter int LANES_MAX  = 4,
  parameter int DATA_BYTES = 4
);
  logic [$clog2(LANES_MAX)-1:0] lanes_number;
  logic [8*DATA_BYTES-1:0]      in_data;
  logic [DATA_BYTES-1:0]        in_bytes_valid;
  logic                         in_last;
  logic                         in_lpm;
  logic                         in_valid;
  logic                         in_ready;
  logic [8*LANES_MAX-1:0]       lane_data;
  logic [LANES_MAX-1:0]         lane_last;
  logic [LANES_MAX-1:0]         lane_lpm;
  logic [LANES_MAX-1:0]         lane_empty;
  logic [LANES_MAX-1:0]         lane_read;
  logic                         busy;

  modport master (
    output lanes_number, in_data, in_bytes_valid, in_last, in_lpm, in_valid, lane_read,
    input  in_ready, lane_data, lane_last, lane_lpm, lane_empty, busy
  );

  modport slave (
    input  lanes_number, in_data, in_bytes_valid, in_last, in_lpm, in_valid, lane_read,
    output in_ready, lane_data, lane_last, lane_lpm, lane_empty, busy
  );
endinterface

// File: rtl/dsi_lane_distributor.sv
// DSI lane distributor: deals packet bytes round-robin over a runtime lane count,
// holds back one byte per lane to tag the packet's last byte, and buffers each lane.

module dsi_lane_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_rd,
  output logic [W-1:0]             o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_cnt
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  logic          w_wr, w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_cnt   = r_cnt;
  assign w_wr    = i_wr && !o_full;
  assign w_rd    = i_rd && !o_empty;
  // Head is forced to zero when empty so stale memory never shows.
  assign o_rdata = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + PW'(1);
      if (w_rd) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end
endmodule

module dsi_lane_distributor #(
  parameter int LANES_MAX  = 4,
  parameter int DATA_BYTES = 4,
  parameter int DEPTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dsi_lane_distributor_if.slave  bus
);
  localparam int WW = $clog2(LANES_MAX + DATA_BYTES + 1) + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [WW-1:0] LMAX = WW'(LANES_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  typedef struct packed {
    logic       lpm;
    logic       last;
    logic [7:0] data;
  } ent_t;

  state_t                          r_state;
  logic                            r_wvld, r_wlast, r_wlpm;
  logic [DATA_BYTES-1:0][7:0]      r_wbytes;
  logic [WW-1:0]                   r_n, r_ptr, r_act, r_rot;
  logic [LANES_MAX-1:0]            r_stg_vld;
  logic [LANES_MAX-1:0][7:0]       r_stg;

  logic [WW-1:0]                   w_in_n, w_lnp1, w_act_req, w_rem, w_k, w_rot_sum, w_rot_nx;
  logic                            w_gap, w_run, w_flush, w_stall, w_go, w_cons;
  logic                            w_flush_stall, w_flush_go, w_ready, w_acc, w_start;
  logic [LANES_MAX-1:0]            w_in_act, w_recv, w_blk, w_room, w_wr, w_full, w_empty;
  logic [LANES_MAX-1:0][7:0]       w_nbyte, w_ld;
  logic [LANES_MAX-1:0][CW-1:0]    w_cnt;
  ent_t [LANES_MAX-1:0]            w_wdata, w_rdata;

  // Byte count of the offered word: only the contiguous run of enables from bit 0.
  always_comb begin
    w_in_n = '0;
    w_gap  = 1'b0;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (!bus.in_bytes_valid[b]) w_gap = 1'b1;
      else if (!w_gap)            w_in_n = w_in_n + WW'(1);
    end
  end

  assign w_lnp1    = WW'(bus.lanes_number) + WW'(1);
  assign w_act_req = (w_lnp1 > LMAX) ? LMAX : w_lnp1;

  assign w_run     = (r_state == S_RUN);
  assign w_flush   = (r_state == S_FLUSH);
  assign w_rem     = r_n - r_ptr;
  assign w_k       = !r_wvld ? '0 : ((w_rem < r_act) ? w_rem : r_act);
  assign w_rot_sum = r_rot + w_k;
  assign w_rot_nx  = (w_rot_sum >= r_act) ? w_rot_sum - r_act : w_rot_sum;

  assign w_stall       = |w_blk;
  assign w_go          = w_run && r_wvld && !w_stall;
  assign w_cons        = w_go && ((r_ptr + w_k) == r_n);
  assign w_flush_stall = |(r_stg_vld & w_full);
  assign w_flush_go    = w_flush && !w_flush_stall;
  assign w_ready       = w_run && (!r_wvld || (w_cons && !r_wlast)) && (&w_room);
  assign w_acc         = bus.in_valid && w_ready;
  assign w_start       = w_run && !r_wvld && !(|r_stg_vld) && (r_rot == '0);

  for (genvar l = 0; l < LANES_MAX; l++) begin : g_lane
    localparam logic [WW-1:0] LI = WW'(l);
    logic [WW-1:0] w_j, w_bi;
    logic [7:0]    w_byte;

    // Offset of this lane from the rotation origin, i.e. which byte of the chunk it takes.
    assign w_j       = (LI >= r_rot) ? LI - r_rot : LI + r_act - r_rot;
    assign w_in_act[l] = (LI < r_act);
    assign w_recv[l] = w_run && r_wvld && w_in_act[l] && (w_j < w_k);
    assign w_bi      = r_ptr + w_j;

    always_comb begin
      w_byte = '0;
      for (int b = 0; b < DATA_BYTES; b++)
        if (w_bi == WW'(b)) w_byte = r_wbytes[b];
    end

    assign w_nbyte[l] = w_byte;
    assign w_blk[l]   = w_recv[l] && r_stg_vld[l] && w_full[l];
    assign w_room[l]  = !w_in_act[l] || (w_cnt[l] < CW'(DEPTH-1));
    assign w_wr[l]    = r_stg_vld[l] && ((w_go && w_recv[l]) || w_flush_go);
    assign w_wdata[l] = w_flush ? ent_t'{lpm: r_wlpm, last: 1'b1, data: r_stg[l]}
                                : ent_t'{lpm: 1'b0,   last: 1'b0, data: r_stg[l]};

    dsi_lane_fifo #(.DEPTH(DEPTH), .W($bits(ent_t))) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr    (w_wr[l]),
      .i_wdata (w_wdata[l]),
      .i_rd    (bus.lane_read[l]),
      .o_rdata (w_rdata[l]),
      .o_empty (w_empty[l]),
      .o_full  (w_full[l]),
      .o_cnt   (w_cnt[l])
    );

    assign w_ld[l]           = w_rdata[l].data;
    assign bus.lane_last[l]  = w_rdata[l].last;
    assign bus.lane_lpm[l]   = w_rdata[l].lpm;
    assign bus.lane_empty[l] = w_empty[l];
  end

  assign bus.lane_data = w_ld;
  assign bus.in_ready  = w_ready;
  assign bus.busy      = r_wvld || (|r_stg_vld) || w_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wvld    <= 1'b0;
      r_wlast   <= 1'b0;
      r_wlpm    <= 1'b0;
      r_wbytes  <= '0;
      r_n       <= '0;
      r_ptr     <= '0;
      r_act     <= '0;
      r_rot     <= '0;
      r_stg_vld <= '0;
      r_stg     <= '0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_RUN;
        S_RUN:   if (w_cons && r_wlast) r_state <= S_FLUSH;
        S_FLUSH: if (!w_flush_stall)    r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase

      // Lane count only changes between packets, never mid-packet.
      if (w_start) r_act <= w_act_req;

      if (w_go) begin
        r_ptr <= r_ptr + w_k;
        r_rot <= w_rot_nx;
      end
      if (w_cons) r_wvld <= 1'b0;
      if (w_acc) begin
        r_wvld   <= 1'b1;
        r_wbytes <= bus.in_data;
        r_n      <= w_in_n;
        r_ptr    <= '0;
        r_wlast  <= bus.in_last;
        r_wlpm   <= bus.in_lpm;
      end

      for (int l = 0; l < LANES_MAX; l++) begin
        if (w_go && w_recv[l]) begin
          r_stg_vld[l] <= 1'b1;
          r_stg[l]     <= w_nbyte[l];
        end
      end

      if (w_flush_go) begin
        r_stg_vld <= '0;
        r_rot     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dsi_lane_distributor.sv
// Bench for dsi_lane_distributor: packet-level lane model plus directed literal checks
// and randomized packets with random lane reads.
module tb_dsi_lane_distributor;
  localparam int L   = 4;
  localparam int D   = 4;
  localparam int DEP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dsi_lane_distributor_if #(.LANES_MAX(L), .DATA_BYTES(D)) bus();

  dsi_lane_distributor #(.LANES_MAX(L), .DATA_BYTES(D), .DEPTH(DEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic         rd_mode = 1'b0;
  logic [L-1:0] man_rd  = '0;
  logic [L-1:0] rnd_rd  = '0;
  assign bus.lane_read = rd_mode ? rnd_rd : man_rd;
  always @(negedge clk) rnd_rd = L'($urandom);

  // Model: byte i of a packet goes to lane i mod A; the final byte on each lane carries last/lpm.
  typedef struct packed { logic [7:0] b; logic last; logic lpm; } ent_t;
  ent_t       q [L][$];
  logic [7:0] pend [L];
  bit         pv [L];
  bit         in_pkt = 0;
  int         pk_act = 1;
  int         pk_idx = 0;
  int         acc_cnt = 0;
  int         m_n;
  bit         m_gap;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < L; l++) begin q[l].delete(); pv[l] = 0; end
      in_pkt = 0;
    end else begin
      for (int l = 0; l < L; l++)
        if (bus.lane_read[l] && !bus.lane_empty[l] && q[l].size() > 0) void'(q[l].pop_front());
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        if (!in_pkt) begin
          pk_act = int'(bus.lanes_number) + 1;
          if (pk_act > L) pk_act = L;
          pk_idx = 0;
          in_pkt = 1;
        end
        m_n = 0; m_gap = 0;
        for (int b = 0; b < D; b++) begin
          if (!bus.in_bytes_valid[b]) m_gap = 1;
          else if (!m_gap) m_n++;
        end
        for (int j = 0; j < m_n; j++) begin
          int ln;
          ln = pk_idx % pk_act;
          if (pv[ln]) q[ln].push_back('{b: pend[ln], last: 1'b0, lpm: 1'b0});
          pend[ln] = bus.in_data[8*j +: 8];
          pv[ln] = 1;
          pk_idx++;
        end
        if (bus.in_last) begin
          for (int l = 0; l < L; l++)
            if (pv[l]) begin q[l].push_back('{b: pend[l], last: 1'b1, lpm: bus.in_lpm}); pv[l] = 0; end
          in_pkt = 0;
        end
      end
    end
  end

  // Compare every visible lane head against the model on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < L; l++) begin
        if (!bus.lane_empty[l]) begin
          ent_t got;
          got = '{b: bus.lane_data[8*l +: 8], last: bus.lane_last[l], lpm: bus.lane_lpm[l]};
          total++;
          if (q[l].size() == 0) begin
            bad++;
            $display("FAIL lane%0d head: got %h, required empty lane", l, got);
          end else if (got !== q[l][0]) begin
            bad++;
            $display("FAIL lane%0d head: got %h, required %h", l, got, q[l][0]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] bv, input logic last, input logic lpm);
    int t = 0;
    bus.in_data = d; bus.in_bytes_valid = bv; bus.in_last = last; bus.in_lpm = lpm;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 2000) begin @(negedge clk); t++; end
    if (!bus.in_ready) chk("send timeout", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 500) begin @(negedge clk); t++; end
    chk("idle", 64'(bus.busy), 64'(0));
  endtask

  task automatic drain();
    int t = 0;
    rd_mode = 1'b1;
    while (bus.lane_empty != '1 && t < 500) begin @(negedge clk); t++; end
    rd_mode = 1'b0;
    chk("drained", 64'(bus.lane_empty), 64'(4'hF));
  endtask

  task automatic pop(input logic [L-1:0] m);
    man_rd = m;
    @(negedge clk);
    man_rd = '0;
  endtask

  initial begin
    int lows, base, qs;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_bytes_valid = '0;
    bus.in_last = 1'b0; bus.in_lpm = 1'b0; bus.lanes_number = 2'd3;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst busy", 64'(bus.busy), 64'(0));
    chk("rst empty", 64'(bus.lane_empty), 64'(4'hF));
    chk("rst data", 64'(bus.lane_data), 64'(0));
    chk("rst last/lpm", 64'({bus.lane_last, bus.lane_lpm}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after rst", 64'(bus.in_ready), 64'(1));

    // 4 lanes, one word, latency to lane_empty
    bus.lanes_number = 2'd3;
    send_word(32'h44332211, 4'hF, 1'b1, 1'b0);
    chk("t1 E0 empty", 64'(bus.lane_empty), 64'(4'hF));
    chk("t1 E0 busy", 64'(bus.busy), 64'(1));
    @(negedge clk);
    chk("t1 E1 empty", 64'(bus.lane_empty), 64'(4'hF));
    @(negedge clk);
    chk("t1 E2 empty", 64'(bus.lane_empty), 64'(4'h0));
    chk("t1 data", 64'(bus.lane_data), 64'(32'h44332211));
    chk("t1 last", 64'(bus.lane_last), 64'(4'hF));
    chk("t1 lpm", 64'(bus.lane_lpm), 64'(4'h0));
    chk("t1 busy", 64'(bus.busy), 64'(0));
    pop(4'hF);

    // 2 lanes, two words
    bus.lanes_number = 2'd1;
    send_word(32'h44332211, 4'hF, 1'b0, 1'b0);
    send_word(32'h00006655, 4'h3, 1'b1, 1'b0);
    wait_idle();
    chk("t2 empty", 64'(bus.lane_empty), 64'(4'hC));
    chk("t2 h0", 64'({bus.lane_data, bus.lane_last}), 64'({32'h00002211, 4'h0}));
    pop(4'h3);
    chk("t2 h1", 64'({bus.lane_data, bus.lane_last}), 64'({32'h00004433, 4'h0}));
    pop(4'h3);
    chk("t2 h2", 64'({bus.lane_data, bus.lane_last}), 64'({32'h00006655, 4'h3}));
    pop(4'h3);

    // 1 lane, lpm, in_ready low through distribution + FLUSH
    bus.lanes_number = 2'd0;
    send_word(32'hDDCCBBAA, 4'hF, 1'b1, 1'b1);
    lows = 0;
    while (!bus.in_ready && lows < 20) begin lows++; @(negedge clk); end
    chk("t3 ready-low cycles", 64'(lows), 64'(5));
    chk("t3 h0", 64'({bus.lane_empty, bus.lane_data, bus.lane_last}), 64'({4'hE, 32'h000000AA, 4'h0}));
    pop(4'h1); pop(4'h1); pop(4'h1);
    chk("t3 tail", 64'({bus.lane_data, bus.lane_last, bus.lane_lpm}), 64'({32'h000000DD, 4'h1, 4'h1}));
    pop(4'h1);

    // 5-byte packet on 4 lanes; upper enables beyond the first gap ignored
    bus.lanes_number = 2'd3;
    send_word(32'h44332211, 4'hF, 1'b0, 1'b0);
    send_word(32'hAABBCC55, 4'b1101, 1'b1, 1'b0);
    wait_idle();
    chk("t4 heads", 64'({bus.lane_data, bus.lane_last}), 64'({32'h44332211, 4'hE}));
    pop(4'hF);
    chk("t4 lane0 tail", 64'({bus.lane_data, bus.lane_last}), 64'({32'h00000055, 4'h1}));
    pop(4'h1);
    send_word(32'h00000077, 4'h1, 1'b1, 1'b0);
    wait_idle();
    chk("t4 next on lane0", 64'({bus.lane_empty, bus.lane_data}), 64'({4'hE, 32'h00000077}));
    pop(4'h1);

    // Backpressure: 12 words with no reads, then drain
    base = acc_cnt;
    fork
      begin
        for (int w = 0; w < 12; w++) send_word($urandom, 4'hF, 1'b0, 1'b0);
        send_word(32'h0, 4'h0, 1'b1, 1'b0);
      end
      begin
        repeat (60) @(negedge clk);
        chk("t5 stalled", 64'(acc_cnt - base < 12), 64'(1));
        chk("t5 ready low", 64'(bus.in_ready), 64'(0));
        rd_mode = 1'b1;
      end
    join
    wait_idle();
    drain();

    // lanes_number change mid-packet
    bus.lanes_number = 2'd3;
    send_word(32'h13121110, 4'hF, 1'b0, 1'b0);
    bus.lanes_number = 2'd1;
    send_word(32'h17161514, 4'hF, 1'b1, 1'b0);
    wait_idle();
    chk("t6 4 lanes", 64'({bus.lane_empty, bus.lane_last}), 64'({4'h0, 4'h0}));
    drain();
    send_word(32'h1B1A1918, 4'hF, 1'b1, 1'b0);
    wait_idle();
    chk("t6 2 lanes", 64'(bus.lane_empty), 64'(4'hC));
    drain();

    // Reset mid-packet
    bus.lanes_number = 2'd3;
    send_word(32'h23222120, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t6 rst empty", 64'(bus.lane_empty), 64'(4'hF));
    chk("t6 rst busy", 64'({bus.busy, bus.in_ready}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    bus.lanes_number = 2'd2;
    send_word(32'h000000EE, 4'h1, 1'b1, 1'b0);
    wait_idle();
    chk("t6 after rst", 64'({bus.lane_empty, bus.lane_data}), 64'({4'hE, 32'h000000EE}));
    pop(4'h1);

    // Random packets with random reads
    rd_mode = 1'b1;
    for (int p = 0; p < 120; p++) begin
      int nw;
      bus.lanes_number = 2'($urandom_range(0, 3));
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        send_word($urandom, 4'($urandom), (w == nw - 1), 1'($urandom));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end
    wait_idle();
    drain();
    qs = 0;
    for (int l = 0; l < L; l++) qs += q[l].size();
    chk("model drained", 64'(qs), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
